// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Instruction register plus Moore sequencer for the simple datapath (regfile,
// A/B/C/status registers, shifter, ALU). A 16-bit instruction is latched while
// idle. On start, the block walks the datapath one step per cycle.
//
// Ports
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   s                 start (level, sampled only while idle)
//   load, in          IR load enable and instruction word (accepted only while idle)
//   w                 1 = idle and ready for s
//   err               trap flag
//   readnum/writenum  regfile read/write register selects
//   write             regfile write enable
//   vsel              writeback mux select: 00 mdata, 01 sximm8, 10 PC, 11 C
//   loada..loads      A, B, C and status register enables
//   asel, bsel        operand selects (A forced to 0 / B from sximm5)
//   shift, ALUop      shifter and ALU controls
//   sximm8, sximm5    sign-extended IR immediates
//
// Build option: define INSTR_SEQ_TRAP_EN to trap on an illegal instruction.
// The trap holds err=1 until reset_n is asserted. When the macro is not
// defined, an illegal instruction behaves as a one-cycle NOP.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int unsigned IW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s,
  input  logic          load,
  input  logic [IW-1:0] in,
  output logic          w,
  output logic          err,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic [1:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_TRAP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;

  // Output registers. They are loaded from the decode of the next state, so
  // each output matches the state that it belongs to with no extra latency.
  logic            w_q, w_d;
  logic [RW-1:0]   readnum_q, readnum_d, writenum_q, writenum_d;
  logic            write_q, write_d, loada_q, loada_d, loadb_q, loadb_d;
  logic            loadc_q, loadc_d, loads_q, loads_d, asel_q, asel_d;
  logic [1:0]      vsel_q, vsel_d, shift_q, shift_d, aluop_q, aluop_d;

  // Decoded fields of the current IR, used for state transitions.
  logic [2:0]      cur_opc;
  logic [1:0]      cur_op;
  // Decoded fields of the next IR, used for the registered output decode.
  logic [2:0]      nxt_opc;
  logic [1:0]      nxt_op;
  logic            nxt_mov_reg, nxt_mvn, nxt_cmp;

  assign cur_opc     = ir_q[15:13];
  assign cur_op      = ir_q[12:11];
  assign nxt_opc     = ir_d[15:13];
  assign nxt_op      = ir_d[12:11];
  assign nxt_mov_reg = (nxt_opc == 3'b110) && (nxt_op == 2'b00);
  assign nxt_mvn     = (nxt_opc == 3'b101) && (nxt_op == 2'b11);
  assign nxt_cmp     = (nxt_opc == 3'b101) && (nxt_op == 2'b01);

  // State, IR and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_WAIT;
      ir_q       <= '0;
      w_q        <= 1'b1;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      vsel_q     <= 2'b00;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      shift_q    <= 2'b00;
      aluop_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      w_q        <= w_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      vsel_q     <= vsel_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      asel_q     <= asel_d;
      shift_q    <= shift_d;
      aluop_q    <= aluop_d;
    end
  end

  // Next state and IR. IR only accepts a new word while idle, so a load
  // together with s on the same edge executes the newly loaded instruction.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if ((cur_opc == 3'b110) && (cur_op == 2'b10))
          state_d = S_WR_IMM;
        else if (((cur_opc == 3'b110) && (cur_op == 2'b00)) ||
                 ((cur_opc == 3'b101) && (cur_op == 2'b11)))
          state_d = S_GET_B;
        else if (cur_opc == 3'b101)
          state_d = S_GET_A;
        else
`ifdef INSTR_SEQ_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_WAIT;
`endif
      end
      S_WR_IMM: state_d = S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = ((cur_opc == 3'b101) && (cur_op == 2'b01)) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_WAIT;
    endcase

    // Moore output decode for the state (and IR) that takes effect next cycle.
    w_d        = (state_d == S_WAIT);
    readnum_d  = ir_d[10:8];
    writenum_d = ir_d[10:8];
    write_d    = 1'b0;
    vsel_d     = 2'b00;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    shift_d    = 2'b00;
    aluop_d    = 2'b00;
    case (state_d)
      S_WR_IMM: begin
        write_d = 1'b1;
        vsel_d  = 2'b01;
      end
      S_GET_A: loada_d = 1'b1;
      S_GET_B: begin
        readnum_d = ir_d[2:0];
        loadb_d   = 1'b1;
      end
      S_EXEC: begin
        shift_d = ir_d[4:3];
        asel_d  = nxt_mov_reg || nxt_mvn;
        aluop_d = nxt_mov_reg ? 2'b00 : nxt_op;
        if (nxt_cmp) begin
          loads_d = 1'b1;
        end else begin
          loadc_d = 1'b1;
          loads_d = !nxt_mov_reg;
        end
      end
      S_WR_REG: begin
        writenum_d = ir_d[7:5];
        vsel_d     = 2'b11;
        write_d    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef INSTR_SEQ_TRAP_EN
  assign err = (state_q == S_TRAP);
`else
  assign err = 1'b0;
`endif

  assign w        = w_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign vsel     = vsel_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign asel     = asel_q;
  assign bsel     = 1'b0;
  assign shift    = shift_q;
  assign ALUop    = aluop_q;
  assign sximm8   = {{(IW-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5   = {{(IW-5){ir_q[4]}}, ir_q[4:0]};

endmodule
